// File: rtl/load_store_unit.sv
// load_store_unit: turns CPU load/store requests into transactions on a
// single-port, big-endian, registered-read, whole-word-write data memory.
// Sub-word stores are done as read-modify-write.
//
// Build option: LSU_ALIGN_CHECK_EN enables the misalignment / illegal-size
// checks and the error response. Without it, low address bits that would be
// misaligned are ignored, size 2'b11 behaves as a word and resp_err is 0.
//
// Handshake: a request is accepted on the posedge where req_valid && req_ready
// are both high; req_ready is only high in IDLE (never during reset), and
// exactly one resp_valid pulse follows every accepted request unless reset
// intervenes.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_wrt,
  input  logic [31:0] mem_dout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_addr_q, lane_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;

  logic        accept;
  logic        req_bad;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept = req_valid && req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q, err_d;

  // Illegal size, odd halfword or non-word-aligned word request
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end
`else
  assign req_bad = 1'b0;
`endif

  // Effective byte lane: offsets that would be misaligned are forced to 0
  always_comb begin
    case (size_q)
      2'b00:   lane = lane_addr_q;
      2'b01:   lane = {lane_addr_q[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  // Pick the addressed byte/half out of the old word (lane 0 = bits 31:24)
  always_comb begin
    case (lane)
      2'd0:    byte_sel = mem_dout[31:24];
      2'd1:    byte_sel = mem_dout[23:16];
      2'd2:    byte_sel = mem_dout[15:8];
      default: byte_sel = mem_dout[7:0];
    endcase
    half_sel = lane[1] ? mem_dout[15:0] : mem_dout[31:16];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_data = mem_dout;
    endcase
  end

  // Merge store data (held right-justified in mem_din_q) into the old word
  always_comb begin
    merged = mem_dout;
    case (size_q)
      2'b00: begin
        case (lane)
          2'd0:    merged[31:24] = mem_din_q[7:0];
          2'd1:    merged[23:16] = mem_din_q[7:0];
          2'd2:    merged[15:8]  = mem_din_q[7:0];
          default: merged[7:0]   = mem_din_q[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) merged[15:0]  = mem_din_q[15:0];
        else         merged[31:16] = mem_din_q[15:0];
      end
      default: merged = mem_din_q;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_addr_d = lane_addr_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
`ifdef LSU_ALIGN_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d        = req_wr;
          size_d      = req_size;
          signed_d    = req_signed;
          lane_addr_d = req_addr[1:0];
          rdata_d     = 32'h0;
`ifdef LSU_ALIGN_CHECK_EN
          err_d       = req_bad;
`endif
          if (req_bad) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ISSUE;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_wr) mem_din_d = req_wdata;
          end
        end
      end
      S_ISSUE: begin
        // Word store writes directly; everything else reads the old word
        if (wr_q && size_q[1]) state_d = S_DONE;
        else                   state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (wr_q) begin
          mem_din_d = merged;
          state_d   = S_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_addr_q <= 2'b00;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_din_q   <= 32'h0;
`ifdef LSU_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_addr_q <= lane_addr_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
`ifdef LSU_ALIGN_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready  = rst_n && (state_q == S_IDLE);
  assign resp_valid = rst_n && (state_q == S_DONE);
  assign resp_rdata = rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  // Memory writes never happen while reset is asserted
  assign mem_wrt    = rst_n && (((state_q == S_ISSUE) && wr_q && size_q[1]) ||
                                (state_q == S_WRITE));

endmodule
